// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the wait-state memory responder: FSM state encoding,
// the data word width and the wait counter width.
// -----------------------------------------------------------------------------
package mem_pkg;

  // Data path width of the processor memory port.
  localparam int WORD_W = 32;

  // Width of the wait-state counter; holds WAIT_CYCLES in the range 0..15.
  localparam int WAIT_W = 4;

  // IDLE: waiting for Req; WAIT: wait states running; RESP: one-cycle response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

endpackage : mem_pkg

// File: rtl/mem_responder_if.sv
// -----------------------------------------------------------------------------
// mem_responder_if
// Processor memory port bundle (request/ready handshake).
//   Req      : access request (master -> slave)
//   Wr       : 1 = write, 0 = read (master -> slave)
//   Address  : byte address (master -> slave)
//   Datain   : write data (master -> slave)
//   Dataout  : read data, held between responses (slave -> master)
//   Ready    : one-cycle response pulse (slave -> master)
//   AddrErr  : access rejected, valid with Ready (slave -> master)
// -----------------------------------------------------------------------------
interface mem_responder_if;

  logic                       Req;
  logic                       Wr;
  logic [mem_pkg::WORD_W-1:0] Address;
  logic [mem_pkg::WORD_W-1:0] Datain;
  logic [mem_pkg::WORD_W-1:0] Dataout;
  logic                       Ready;
  logic                       AddrErr;

  // Processor side.
  modport master (
    output Req, Wr, Address, Datain,
    input  Dataout, Ready, AddrErr
  );

  // Memory side.
  modport slave (
    input  Req, Wr, Address, Datain,
    output Dataout, Ready, AddrErr
  );

endinterface : mem_responder_if

// File: rtl/mem_word_array.sv
// -----------------------------------------------------------------------------
// mem_word_array
// Single-port synchronous word RAM with a registered read port.
//   i_clk    : clock
//   i_rst    : asynchronous active-high reset (read register only)
//   i_we     : write enable, writes i_wdata to word i_addr
//   i_rd_en  : loads the read register from word i_addr
//   i_rd_clr : clears the read register (takes priority over i_rd_en)
//   i_addr   : word index
//   i_wdata  : write data
//   o_rdata  : registered read data, holds between loads
// -----------------------------------------------------------------------------
module mem_word_array
  import mem_pkg::*;
#(
  parameter  int DEPTH_WORDS = 256,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic              i_rd_en,
  input  logic              i_rd_clr,
  input  logic [IDX_W-1:0]  i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

  // NOTE: the storage array has no reset; resetting it would turn the RAM
  // into a flop bank. Only the read register below is reset.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rdata <= '0;
    end else if (i_rd_clr) begin
      o_rdata <= '0;
    end else if (i_rd_en) begin
      o_rdata <= r_mem[i_addr];
    end
  end

endmodule : mem_word_array

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Word-addressed memory responder with WAIT_CYCLES wait states between
// request acceptance and the one-cycle Ready pulse. Misaligned or
// out-of-range accesses are rejected with AddrErr alongside Ready.
//   Clk   : clock, all state updates on the rising edge
//   Reset : asynchronous active-high reset
//   bus   : memory port (slave side), see mem_responder_if
// -----------------------------------------------------------------------------
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           Clk,
  input  logic           Reset,
  mem_responder_if.slave bus
);

  localparam int                IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [WORD_W-1:0] ADDR_LIMIT = WORD_W'(4 * DEPTH_WORDS);
  localparam logic [WAIT_W-1:0] WAIT_LOAD  = WAIT_W'(WAIT_CYCLES);
  localparam logic [WAIT_W-1:0] CNT_ONE    = WAIT_W'(1);

  mem_state_t        r_state;
  mem_state_t        w_next;
  logic [WAIT_W-1:0] r_cnt;
  logic              r_wr;
  logic [WORD_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic              r_ready;
  logic              r_addr_err;

  logic              w_in_idle;
  logic              w_accept;
  logic [WORD_W-1:0] w_acc_addr;
  logic              w_acc_wr;
  logic              w_valid;
  logic              w_enter_resp;
  logic              w_we;
  logic              w_rd_en;
  logic              w_rd_clr;
  logic [WORD_W-1:0] w_rdata;

  assign w_in_idle = (r_state == IDLE);
  assign w_accept  = w_in_idle && bus.Req;

  // With zero wait states RESP is entered on the acceptance edge itself, so
  // the access attributes come straight from the bus while IDLE and from the
  // latched copies afterwards. Both views hold the same request.
  assign w_acc_addr = w_in_idle ? bus.Address : r_addr;
  assign w_acc_wr   = w_in_idle ? bus.Wr      : r_wr;

  // Full 32-bit range check: high addresses must not alias into the array.
  assign w_valid = (w_acc_addr[1:0] == 2'b00) && (w_acc_addr < ADDR_LIMIT);

  // NOTE: every signal written in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.Req) w_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (r_cnt == CNT_ONE) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_enter_resp = (w_next == RESP) && (r_state != RESP);

  // Writes commit on the edge leaving RESP, so a reset during WAIT discards
  // them. Reads and rejections update Dataout on the edge entering RESP.
  assign w_we     = (r_state == RESP) && r_wr && w_valid;
  assign w_rd_en  = w_enter_resp && !w_acc_wr && w_valid;
  assign w_rd_clr = w_enter_resp && !w_valid;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_ready    <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_ready    <= w_enter_resp;
      r_addr_err <= w_enter_resp && !w_valid;
      if (w_accept) begin
        r_cnt   <= WAIT_LOAD;
        r_wr    <= bus.Wr;
        r_addr  <= bus.Address;
        r_wdata <= bus.Datain;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  mem_word_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .i_clk    (Clk),
    .i_rst    (Reset),
    .i_we     (w_we),
    .i_rd_en  (w_rd_en),
    .i_rd_clr (w_rd_clr),
    .i_addr   (w_acc_addr[IDX_W+1:2]),
    .i_wdata  (r_wdata),
    .o_rdata  (w_rdata)
  );

  assign bus.Dataout = w_rdata;
  assign bus.Ready   = r_ready;
  assign bus.AddrErr = r_addr_err;

endmodule : mem_responder
